// File: rtl/writeback_regfile_pkg.sv
// ---------------------------------------------------------------------------
// writeback_regfile_pkg
//
// Shared definitions for the writeback stage and its register file.
//   - Datapath sizing: WORD_WIDTH, REG_COUNT, REGADDR_WIDTH.
//   - Control bus layout produced by the memory stage (CBUS_WIDTH bits).
//     The low bits carry the memory-stage fields (MEMCB_*). The writeback
//     fields (WB_ENABLE, WB_REG_*) sit above them.
//   - wb_ctrl_t: the decoded writeback view of the control bus.
// ---------------------------------------------------------------------------
package writeback_regfile_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int REG_COUNT     = 8;
    localparam int REGADDR_WIDTH = 3;

    // Memory-stage control fields. These are consumed upstream and only
    // pass through this stage.
    localparam int MEMCB_MEM_READ  = 0;
    localparam int MEMCB_MEM_WRITE = 1;
    localparam int MEMCB_SIZE_LSB  = 2;
    localparam int MEMCB_SIZE_MSB  = 3;
    localparam int MEMCB_SIGN_EXT  = 4;

    // Writeback control fields
    localparam int WB_ENABLE  = 5;
    localparam int WB_REG_LSB = 6;
    localparam int WB_REG_MSB = 8;

    localparam int CBUS_WIDTH = 9;

    typedef struct packed {
        logic                     enable;
        logic [REGADDR_WIDTH-1:0] dest;
    } wb_ctrl_t;

endpackage

// File: rtl/writeback_regfile_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//
// This is the architectural register file. It has two read ports and one
// write port. r0 is hard-wired to zero. Both read ports are combinational.
// Each read port also sees a write-through of the write being performed in
// the same cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; clears every register
//   wr_en      in   write strobe; writes to address 0 are discarded
//   wr_addr    in   write address
//   wr_data    in   write data
//   rd_addr_a  in   read address, port A
//   rd_data_a  out  read data, port A (combinational)
//   rd_addr_b  in   read address, port B
//   rd_data_b  out  read data, port B (combinational)
// ---------------------------------------------------------------------------
module regfile_2r1w
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_WIDTH,
    parameter int DEPTH      = REG_COUNT,
    parameter int ADDR_WIDTH = REGADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // Entry 0 is reset like the others but is never written. It is also
    // never read, because the read muxes force zero for address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Port A: r0 reads zero. Next priority is the write-through of this
    // cycle's write. Otherwise the stored value is returned.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            if (wr_en && (rd_addr_a == wr_addr)) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = regs[rd_addr_a];
            end
        end
    end

    // Port B uses the same priority as port A.
    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            if (wr_en && (rd_addr_b == wr_addr)) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = regs[rd_addr_b];
            end
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//
// This is the final pipeline stage. It commits memory-stage results into an
// 8 x 16-bit register file. It serves decode through two combinational read
// ports with write-through. It drives a registered forwarding port for the
// ALU. It counts retired writes for debug.
//
// A load reaches this stage in two beats. The first beat is stale and the
// second beat carries the memory data. The memory stage raises MemStall
// during the cycle before the stale beat arrives. That flag is delayed
// here by one edge, so the stale beat is never committed.
//
// Ports:
//   gclk          in   clock; all state updates on the rising edge
//   rst           in   synchronous active-high reset
//   InDataBus     in   result word from the memory stage
//   InControlBus  in   control bus from the memory stage
//   MemStall      in   memory-stage stall flag for the current cycle
//   RdAddrA/B     in   decode read addresses
//   RdDataA/B     out  decode read data (combinational, with write-through)
//   FwdValid      out  FwdReg/FwdData describe a commit from the last edge
//   FwdReg        out  destination of the most recent commit
//   FwdData       out  value of the most recent commit
//   RetireCount   out  number of committed writes, wraps at 2^16
// ---------------------------------------------------------------------------
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int WORD_WIDTH    = writeback_regfile_pkg::WORD_WIDTH,
    parameter int REG_COUNT     = writeback_regfile_pkg::REG_COUNT,
    parameter int REGADDR_WIDTH = writeback_regfile_pkg::REGADDR_WIDTH,
    parameter int CBUS_WIDTH    = writeback_regfile_pkg::CBUS_WIDTH
) (
    input  logic                     gclk,
    input  logic                     rst,
    input  logic [WORD_WIDTH-1:0]    InDataBus,
    input  logic [CBUS_WIDTH-1:0]    InControlBus,
    input  logic                     MemStall,
    input  logic [REGADDR_WIDTH-1:0] RdAddrA,
    input  logic [REGADDR_WIDTH-1:0] RdAddrB,
    output logic [WORD_WIDTH-1:0]    RdDataA,
    output logic [WORD_WIDTH-1:0]    RdDataB,
    output logic                     FwdValid,
    output logic [REGADDR_WIDTH-1:0] FwdReg,
    output logic [WORD_WIDTH-1:0]    FwdData,
    output logic [15:0]              RetireCount
);

    wb_ctrl_t wb_ctrl;
    logic     stall_q;
    logic     commit;
    logic     unused_memcb;

    assign wb_ctrl.enable = InControlBus[WB_ENABLE];
    assign wb_ctrl.dest   = InControlBus[WB_REG_MSB:WB_REG_LSB];

    // The memory-stage fields have already been acted on upstream.
    assign unused_memcb = ^InControlBus[WB_ENABLE-1:0];

    // A write to r0 is not an architectural write, so it is neither
    // forwarded nor counted. stall_q marks the bus as holding a stale beat.
    assign commit = wb_ctrl.enable && !stall_q && (wb_ctrl.dest != '0);

    regfile_2r1w #(
        .DATA_WIDTH (WORD_WIDTH),
        .DEPTH      (REG_COUNT),
        .ADDR_WIDTH (REGADDR_WIDTH)
    ) u_regfile (
        .clk       (gclk),
        .rst       (rst),
        .wr_en     (commit),
        .wr_addr   (wb_ctrl.dest),
        .wr_data   (InDataBus),
        .rd_addr_a (RdAddrA),
        .rd_data_a (RdDataA),
        .rd_addr_b (RdAddrB),
        .rd_data_b (RdDataB)
    );

    // Reset takes priority over a commit on the same edge. Reset also
    // clears stall_q, so a load interrupted by reset cannot leave a stale
    // suppression behind. FwdReg/FwdData keep their last values when there
    // is no commit. Only FwdValid drops in that case.
    always_ff @(posedge gclk) begin
        if (rst) begin
            stall_q     <= 1'b0;
            FwdValid    <= 1'b0;
            FwdReg      <= '0;
            FwdData     <= '0;
            RetireCount <= '0;
        end else begin
            stall_q <= MemStall;
            if (commit) begin
                FwdValid    <= 1'b1;
                FwdReg      <= wb_ctrl.dest;
                FwdData     <= InDataBus;
                RetireCount <= RetireCount + 16'd1;
            end else begin
                FwdValid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_writeback_regfile
//
// Self-checking bench for writeback_regfile. It applies directed scenarios
// and a randomized phase. The DUT is compared against a behavioural model
// of the architectural register state.
// ---------------------------------------------------------------------------
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic                     gclk = 1'b0;
    logic                     rst;
    logic [WORD_WIDTH-1:0]    InDataBus;
    logic [CBUS_WIDTH-1:0]    InControlBus;
    logic                     MemStall;
    logic [REGADDR_WIDTH-1:0] RdAddrA;
    logic [REGADDR_WIDTH-1:0] RdAddrB;
    logic [WORD_WIDTH-1:0]    RdDataA;
    logic [WORD_WIDTH-1:0]    RdDataB;
    logic                     FwdValid;
    logic [REGADDR_WIDTH-1:0] FwdReg;
    logic [WORD_WIDTH-1:0]    FwdData;
    logic [15:0]              RetireCount;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the architectural state
    logic [15:0] model_regs [8];
    logic        model_stale = 1'b0;
    logic        model_fwd_valid = 1'b0;
    logic [2:0]  model_fwd_reg = 3'd0;
    logic [15:0] model_fwd_data = 16'h0;
    int          model_count = 0;

    always #5 gclk = ~gclk;

    writeback_regfile dut (
        .gclk         (gclk),
        .rst          (rst),
        .InDataBus    (InDataBus),
        .InControlBus (InControlBus),
        .MemStall     (MemStall),
        .RdAddrA      (RdAddrA),
        .RdAddrB      (RdAddrB),
        .RdDataA      (RdDataA),
        .RdDataB      (RdDataB),
        .FwdValid     (FwdValid),
        .FwdReg       (FwdReg),
        .FwdData      (FwdData),
        .RetireCount  (RetireCount)
    );

    function automatic logic [15:0] modelRead(input logic [2:0] addr, input logic wr,
                                              input logic [2:0] dest, input logic [15:0] data);
        if (addr == 3'd0) return 16'h0;
        if (wr && addr == dest) return data;
        return model_regs[addr];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of bus activity. First check the combinational
    // reads, then advance the model across the edge and check the
    // registered outputs.
    task automatic applyStimulus(input logic do_rst, input logic [15:0] data,
                                 input logic wb_en, input logic [2:0] dest,
                                 input logic stall, input logic [2:0] addr_a,
                                 input logic [2:0] addr_b, input logic check_en);
        logic                  wr;
        logic [CBUS_WIDTH-1:0] cbus;
        @(negedge gclk);
        cbus = CBUS_WIDTH'($urandom);
        cbus[WB_ENABLE] = wb_en;
        cbus[WB_REG_MSB:WB_REG_LSB] = dest;
        rst          = do_rst;
        InDataBus    = data;
        InControlBus = cbus;
        MemStall     = stall;
        RdAddrA      = addr_a;
        RdAddrB      = addr_b;
        wr = wb_en && !model_stale && (dest != 3'd0);
        #1;
        if (check_en) begin
            checkOutput("rd_a", 32'(RdDataA), 32'(modelRead(addr_a, wr, dest, data)));
            checkOutput("rd_b", 32'(RdDataB), 32'(modelRead(addr_b, wr, dest, data)));
        end
        @(posedge gclk);
        if (do_rst) begin
            for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;
            model_stale     = 1'b0;
            model_fwd_valid = 1'b0;
            model_fwd_reg   = 3'd0;
            model_fwd_data  = 16'h0;
            model_count     = 0;
        end else begin
            if (wr) begin
                model_regs[dest] = data;
                model_fwd_valid  = 1'b1;
                model_fwd_reg    = dest;
                model_fwd_data   = data;
                model_count      = (model_count + 1) % 65536;
            end else begin
                model_fwd_valid  = 1'b0;
            end
            model_stale = stall;
        end
        #1;
        if (check_en) begin
            checkOutput("fwd_valid", 32'(FwdValid), 32'(model_fwd_valid));
            checkOutput("fwd_reg", 32'(FwdReg), 32'(model_fwd_reg));
            checkOutput("fwd_data", 32'(FwdData), 32'(model_fwd_data));
            checkOutput("retire_count", 32'(RetireCount), 32'(model_count));
        end
    endtask

    initial begin
        rst = 1'b1; InDataBus = '0; InControlBus = '0; MemStall = 1'b0;
        RdAddrA = '0; RdAddrB = '0;
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;

        // Reset, then sweep every address on both ports
        applyStimulus(1'b1, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 3'(a), 3'(7 - a), 1'b1);
        end
        checkOutput("reset_fwd_valid", 32'(FwdValid), 32'd0);
        checkOutput("reset_count", 32'(RetireCount), 32'd0);

        // ALU writeback with bypass on port A
        applyStimulus(1'b0, 16'h1234, 1'b1, 3'd3, 1'b0, 3'd3, 3'd3, 1'b1);
        checkOutput("alu_fwd_valid", 32'(FwdValid), 32'd1);
        checkOutput("alu_fwd_reg", 32'(FwdReg), 32'd3);
        checkOutput("alu_fwd_data", 32'(FwdData), 32'h1234);
        checkOutput("alu_count", 32'(RetireCount), 32'd1);

        // Write to r0 is dropped
        applyStimulus(1'b0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkOutput("r0_fwd_valid", 32'(FwdValid), 32'd0);
        checkOutput("r0_count", 32'(RetireCount), 32'd1);

        // Load: the stale beat BEEF is suppressed and CAFE commits once
        applyStimulus(1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd5, 3'd5, 1'b1);
        applyStimulus(1'b0, 16'hBEEF, 1'b1, 3'd5, 1'b0, 3'd5, 3'd5, 1'b1);
        checkOutput("load_stale_fwd_valid", 32'(FwdValid), 32'd0);
        applyStimulus(1'b0, 16'hCAFE, 1'b1, 3'd5, 1'b0, 3'd5, 3'd0, 1'b1);
        checkOutput("load_fwd_data", 32'(FwdData), 32'hCAFE);
        checkOutput("load_count", 32'(RetireCount), 32'd2);
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd3, 1'b1);
        checkOutput("load_r5", 32'(RdDataA), 32'hCAFE);

        // Back-to-back stalls
        applyStimulus(1'b0, 16'h1111, 1'b1, 3'd6, 1'b1, 3'd6, 3'd6, 1'b1);
        applyStimulus(1'b0, 16'h2222, 1'b1, 3'd6, 1'b1, 3'd6, 3'd6, 1'b1);
        applyStimulus(1'b0, 16'h3333, 1'b1, 3'd6, 1'b0, 3'd6, 3'd6, 1'b1);
        applyStimulus(1'b0, 16'h4444, 1'b1, 3'd6, 1'b0, 3'd6, 3'd6, 1'b1);

        // Reset during a load, then a commit right after
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd1, 3'd2, 1'b1);
        applyStimulus(1'b1, 16'h7777, 1'b1, 3'd4, 1'b0, 3'd4, 3'd1, 1'b1);
        applyStimulus(1'b0, 16'h5555, 1'b1, 3'd4, 1'b0, 3'd4, 3'd4, 1'b1);
        checkOutput("post_reset_count", 32'(RetireCount), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 49) == 0), 16'($urandom),
                          1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 1'b1);
        end

        // Counter wrap: run commits up to 65535, then commit once more
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        while (model_count != 65535) begin
            applyStimulus(1'b0, 16'($urandom), 1'b1, 3'($urandom_range(1, 7)),
                          1'b0, 3'd1, 3'd2, 1'b0);
        end
        checkOutput("pre_wrap_count", 32'(RetireCount), 32'hFFFF);
        applyStimulus(1'b0, 16'h5A5A, 1'b1, 3'd4, 1'b0, 3'd4, 3'd4, 1'b1);
        checkOutput("wrap_count", 32'(RetireCount), 32'd0);

        // Reset wins over a simultaneous commit
        applyStimulus(1'b1, 16'h00AA, 1'b1, 3'd2, 1'b0, 3'd2, 3'd2, 1'b1);
        checkOutput("rst_commit_count", 32'(RetireCount), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2, 1'b1);
        checkOutput("rst_commit_r2", 32'(RdDataA), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
